// File: rtl/intxn_phase_sched_pkg.sv
// Shared types for the intersection phase scheduler: FSM state encoding,
// phase indices, lamp codes and the round-robin next-phase search.
package intxn_phase_sched_pkg;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_e;

  localparam logic [1:0] PH_NS_THRU = 2'd0;
  localparam logic [1:0] PH_EW_THRU = 2'd1;
  localparam logic [1:0] PH_NS_LEFT = 2'd2;
  localparam logic [1:0] PH_EW_LEFT = 2'd3;

  localparam logic [3:0] LAMP_OFF = 4'b0000;
  localparam logic [3:0] LAMP_PH0 = 4'b0001;

  function automatic logic [3:0] ph_onehot(input logic [1:0] ph);
    return LAMP_PH0 << ph;
  endfunction

  // First demanded phase after ph, wrapping 3->0; scanning k downward lets the nearest win.
  function automatic logic [1:0] next_demand(input logic [3:0] dem, input logic [1:0] ph);
    logic [1:0] idx;
    logic [1:0] sel;
    sel = ph;
    for (int k = 3; k >= 1; k--) begin
      idx = ph + 2'(k);
      if (dem[idx]) sel = idx;
    end
    return sel;
  endfunction

endpackage

// File: rtl/intxn_phase_sched_sec_tick.sv
// Whole-second tick generator: counts 0..CLK_HZ-1, pulses tick on the last count,
// and restarts from zero on clr so every timed interval begins on a clean boundary.
module intxn_sec_tick #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr || cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == CNT_MAX);

endmodule

// File: rtl/intxn_phase_sched.sv
// Four-phase intersection scheduler with latched calls, min/max green, yellow and
// all-red clearance. Optional pedestrian walk on phase 1 with macro INTXN_PED_EN.
module intxn_phase_sched
  import intxn_phase_sched_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_S  = 2,
  parameter int ALLRED_S  = 1
`ifdef INTXN_PED_EN
  ,
  parameter int PED_WALK  = 4
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
`ifdef INTXN_PED_EN
  input  logic       ped_btn,
  output logic       walk,
`endif
  output logic [3:0] grant,
  output logic [3:0] yellow,
  output logic       all_red,
  output logic [1:0] phase,
  output logic       sec_tick
);

  localparam logic [3:0] GMIN = 4'(GREEN_MIN);
  localparam logic [3:0] GMAX = 4'(GREEN_MAX);
  localparam logic [3:0] YEL  = 4'(YELLOW_S);
  localparam logic [3:0] AR   = 4'(ALLRED_S);

  state_e     state;
  logic [1:0] next_phase;
  logic [3:0] pending;
  logic [3:0] dem;
  logic [3:0] sec;
  logic [3:0] gmin;
  logic [3:0] set_mask;
  logic [3:0] clr_mask;
  logic       other;
  logic       trans;
  logic       tick;

  function automatic logic [3:0] sec_sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

`ifdef INTXN_PED_EN
  localparam int PED_GMIN_I = (GREEN_MIN > PED_WALK + 1) ? GREEN_MIN : PED_WALK + 1;
  localparam logic [3:0] PED_GMIN  = 4'(PED_GMIN_I);
  localparam logic [3:0] WALK_LAST = 4'(PED_WALK - 1);

  logic ped_pend;
  logic ped_grn;
  logic enter_p1;
`endif

  intxn_sec_tick #(
    .CLK_HZ (CLK_HZ)
  ) u_sec_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (trans),
    .tick    (tick)
  );

  assign sec_tick = tick;

  // Demand seen by the scheduler: latched calls plus the rest-phase recall.
  always_comb begin
    dem = pending;
    if (phase != PH_NS_THRU) dem[PH_NS_THRU] = 1'b1;
    gmin = GMIN;
`ifdef INTXN_PED_EN
    if (ped_pend) dem[PH_EW_THRU] = 1'b1;
    if (ped_grn)  gmin = PED_GMIN;
`endif
    other = |(dem & ~ph_onehot(phase));

    trans = 1'b0;
    case (state)
      ST_GREEN:  trans = other && (sec >= gmin) && (!req[phase] || sec >= GMAX);
      ST_YELLOW: trans = (sec >= YEL);
      ST_ALLRED: trans = (sec >= AR);
      default:   trans = 1'b1;
    endcase

    set_mask = (state == ST_GREEN) ? ph_onehot(phase) : LAMP_OFF;
    clr_mask = (state == ST_ALLRED && trans) ? ph_onehot(next_phase) : LAMP_OFF;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_GREEN;
      phase      <= PH_NS_THRU;
      next_phase <= PH_NS_THRU;
      grant      <= LAMP_PH0;
      yellow     <= LAMP_OFF;
      all_red    <= 1'b0;
    end else if (trans) begin
      case (state)
        ST_GREEN: begin
          state      <= ST_YELLOW;
          next_phase <= next_demand(dem, phase);
          grant      <= LAMP_OFF;
          yellow     <= ph_onehot(phase);
        end
        ST_YELLOW: begin
          state   <= ST_ALLRED;
          yellow  <= LAMP_OFF;
          all_red <= 1'b1;
        end
        ST_ALLRED: begin
          state   <= ST_GREEN;
          all_red <= 1'b0;
          phase   <= next_phase;
          grant   <= ph_onehot(next_phase);
        end
        default: begin
          state   <= ST_GREEN;
          phase   <= PH_NS_THRU;
          grant   <= LAMP_PH0;
          yellow  <= LAMP_OFF;
          all_red <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec     <= 4'd0;
      pending <= 4'd0;
    end else begin
      if (trans) sec <= 4'd0;
      else if (tick) sec <= sec_sat_inc(sec);
      pending <= (pending | (req & ~set_mask)) & ~clr_mask;
    end
  end

`ifdef INTXN_PED_EN
  assign enter_p1 = (state == ST_ALLRED) && trans && (next_phase == PH_EW_THRU);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_pend <= 1'b0;
      ped_grn  <= 1'b0;
      walk     <= 1'b0;
    end else begin
      ped_pend <= enter_p1 ? 1'b0 : (ped_pend | ped_btn);
      if (enter_p1 && ped_pend) begin
        walk    <= 1'b1;
        ped_grn <= 1'b1;
      end else if (trans) begin
        walk    <= 1'b0;
        ped_grn <= 1'b0;
      end else if (tick && sec == WALK_LAST) begin
        walk <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_intxn_phase_sched.sv
// Directed bench for intxn_phase_sched at CLK_HZ=10 (one second = 10 cycles).
module tb_intxn_phase_sched;
  import intxn_phase_sched_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] req = 4'd0;
  logic [3:0] grant;
  logic [3:0] yellow;
  logic       all_red;
  logic [1:0] phase;
  logic       sec_tick;

  int n_chk = 0;
  int n_err = 0;
  int cyc_cnt = 0;
  int base = 0;
  logic seen_bad;

  intxn_phase_sched #(
    .CLK_HZ    (10),
    .GREEN_MIN (5),
    .GREEN_MAX (10),
    .YELLOW_S  (2),
    .ALLRED_S  (1)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .grant    (grant),
    .yellow   (yellow),
    .all_red  (all_red),
    .phase    (phase),
    .sec_tick (sec_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, cyc_cnt - base);
    end
  endtask

  // Move to just after rising edge e counted from reset release.
  task automatic at_edge(input int e);
    while (cyc_cnt - base < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lamps(input string tag, input int e, input logic [3:0] g,
                       input logic [3:0] y, input logic ar, input logic [1:0] ph);
    at_edge(e);
    check({tag, "_grant"}, grant, g);
    check({tag, "_yellow"}, yellow, y);
    check({tag, "_allred"}, all_red, ar);
    check({tag, "_phase"}, phase, ph);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_grant", grant, 4'b0001);
    check("rst_yellow", yellow, 4'b0000);
    check("rst_allred", all_red, 1'b0);
    check("rst_phase", phase, 2'd0);
    check("rst_tick", sec_tick, 1'b0);
    reset_n = 1'b1;
    base = cyc_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Async reset during YELLOW of phase 2
    do_reset();
    req = 4'b0100;
    at_edge(1);
    req = 4'b0000;
    lamps("t1_g2", 83, 4'b0100, 4'b0000, 1'b0, 2'd2);
    lamps("t1_y2", 134, 4'b0000, 4'b0100, 1'b0, 2'd2);
    at_edge(140);
    #2;
    reset_n = 1'b0;
    #1;
    check("t1_async_grant", grant, 4'b0001);
    check("t1_async_yellow", yellow, 4'b0000);
    check("t1_async_allred", all_red, 1'b0);
    check("t1_async_phase", phase, 2'd0);

    // Idle: rest on phase 0
    do_reset();
    seen_bad = 1'b0;
    for (int i = 1; i <= 500; i++) begin
      at_edge(i);
      if (grant !== 4'b0001 || yellow !== 4'b0000 || all_red !== 1'b0) seen_bad = 1'b1;
    end
    check("t2_idle", seen_bad, 1'b0);
    check("t2_phase", phase, 2'd0);

    // Single call on phase 1, then recall to phase 0
    do_reset();
    req = 4'b0010;
    at_edge(1);
    req = 4'b0000;
    at_edge(8);
    check("t3_tick8", sec_tick, 1'b0);
    at_edge(9);
    check("t3_tick9", sec_tick, 1'b1);
    lamps("t3_g0_end", 50, 4'b0001, 4'b0000, 1'b0, 2'd0);
    lamps("t3_y0", 51, 4'b0000, 4'b0001, 1'b0, 2'd0);
    lamps("t3_y0_end", 71, 4'b0000, 4'b0001, 1'b0, 2'd0);
    lamps("t3_ar", 72, 4'b0000, 4'b0000, 1'b1, 2'd0);
    lamps("t3_ar_end", 82, 4'b0000, 4'b0000, 1'b1, 2'd0);
    lamps("t3_g1", 83, 4'b0010, 4'b0000, 1'b0, 2'd1);
    lamps("t3_g1_end", 133, 4'b0010, 4'b0000, 1'b0, 2'd1);
    lamps("t3_y1", 134, 4'b0000, 4'b0010, 1'b0, 2'd1);
    lamps("t3_ar1", 155, 4'b0000, 4'b0000, 1'b1, 2'd1);
    lamps("t3_ret0", 166, 4'b0001, 4'b0000, 1'b0, 2'd0);

    // Held call on phase 1 with phase 3 waiting: runs to max green
    do_reset();
    req = 4'b0010;
    lamps("t4_g1", 83, 4'b0010, 4'b0000, 1'b0, 2'd1);
    req = 4'b1010;
    at_edge(84);
    req = 4'b0010;
    lamps("t4_past_min", 134, 4'b0010, 4'b0000, 1'b0, 2'd1);
    lamps("t4_g1_end", 183, 4'b0010, 4'b0000, 1'b0, 2'd1);
    lamps("t4_y1_max", 184, 4'b0000, 4'b0010, 1'b0, 2'd1);
    lamps("t4_ar", 205, 4'b0000, 4'b0000, 1'b1, 2'd1);
    lamps("t4_g3", 216, 4'b1000, 4'b0000, 1'b0, 2'd3);
    req = 4'b0000;

    // Calls 1,2,3 latched together: round-robin then recall
    do_reset();
    req = 4'b1110;
    at_edge(1);
    req = 4'b0000;
    lamps("t5_g1", 83, 4'b0010, 4'b0000, 1'b0, 2'd1);
    lamps("t5_g2", 166, 4'b0100, 4'b0000, 1'b0, 2'd2);
    lamps("t5_g3", 249, 4'b1000, 4'b0000, 1'b0, 2'd3);
    lamps("t5_y3", 300, 4'b0000, 4'b1000, 1'b0, 2'd3);
    lamps("t5_ar3", 331, 4'b0000, 4'b0000, 1'b1, 2'd3);
    lamps("t5_g0", 332, 4'b0001, 4'b0000, 1'b0, 2'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
